// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display scheduler slice.
package disp_sched_pkg;

  // Owner of the display content
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int         DISP_DIGITS = 8;
  localparam logic [7:0] OFF_ALL     = 8'hFF;
  localparam logic [1:0] GNT_NONE    = 2'b00;

  // One-hot grant seen by the requesters for a given owner state
  function automatic logic [1:0] gnt_of(input state_t s);
    logic [1:0] g;
    g = GNT_NONE;
    case (s)
      OWN0:    g = 2'b01;
      OWN1:    g = 2'b10;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Digit-scan prescaler and frame counter. Produces the registered
// one-cycle DISP_CE pulse and the FRAME_END pulse on the 8th digit.
module disp_tick_gen
  import disp_sched_pkg::*;
#(
  parameter int CE_DIV = 100000
) (
  input  logic CLK,
  input  logic RST_N,
  output logic DISP_CE,
  output logic FRAME_END
);

  localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  logic [CW-1:0] r_ce_cnt;
  logic [2:0]    r_frm_cnt;
  logic          r_disp_ce;
  logic          r_frame_end;
  logic          w_ce_last;
  logic          w_ce_pre;

  // The pulses are registered, so they are decoded one count early to
  // land in the cycle where the prescaler sits at its terminal value.
  assign w_ce_last = (r_ce_cnt == CW'(CE_DIV - 1));
  assign w_ce_pre  = (r_ce_cnt == CW'(CE_DIV - 2));

  // Prescaler wraps every CE_DIV cycles; frame counter advances per digit pulse
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ce_cnt    <= '0;
      r_frm_cnt   <= '0;
      r_disp_ce   <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_ce_cnt    <= w_ce_last ? '0 : r_ce_cnt + 1'b1;
      r_disp_ce   <= w_ce_pre;
      r_frame_end <= w_ce_pre && (r_frm_cnt == 3'(DISP_DIGITS - 1));
      if (r_disp_ce) begin
        r_frm_cnt <= r_frm_cnt + 3'd1;
      end
    end
  end

  assign DISP_CE   = r_disp_ce;
  assign FRAME_END = r_frame_end;

endmodule

// File: rtl/disp_scheduler.sv
// Display scheduler: arbitrates two content requesters at frame
// boundaries, applies a hold before high-priority preemption, and
// blinks selected digits. All outputs only change on FRAME_END.
module disp_scheduler
  import disp_sched_pkg::*;
#(
  parameter int CE_DIV       = 100000,
  parameter int BLINK_FRAMES = 64,
  parameter int HOLD_FRAMES  = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  REQ,
  input  logic [31:0] HEX0,
  input  logic [31:0] HEX1,
  input  logic [7:0]  DP0,
  input  logic [7:0]  DP1,
  input  logic [7:0]  OFF0,
  input  logic [7:0]  OFF1,
  input  logic [7:0]  BLINK0,
  input  logic [7:0]  BLINK1,
  output logic [1:0]  GNT,
  output logic        DISP_CE,
  output logic        FRAME_END,
  output logic [31:0] HEX_OUT,
  output logic [7:0]  DP_OUT,
  output logic [7:0]  OFF_OUT
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_gnt;
  logic [BW-1:0] r_blk_cnt;
  logic          r_phase;
  logic [HW-1:0] r_hold_cnt;
  logic [31:0]   r_hex;
  logic [7:0]    r_dp;
  logic [7:0]    r_off;

  logic          w_frame_end;
  logic          w_blk_wrap;
  logic          w_phase_nxt;
  logic          w_hold_ok;
  logic          w_hold_sat;
  logic [31:0]   w_hex_nxt;
  logic [7:0]    w_dp_nxt;
  logic [7:0]    w_off_nxt;

  disp_tick_gen #(
    .CE_DIV(CE_DIV)
  ) u_tick (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .DISP_CE  (DISP_CE),
    .FRAME_END(w_frame_end)
  );

  assign FRAME_END  = w_frame_end;
  assign w_blk_wrap = (r_blk_cnt == BW'(BLINK_FRAMES - 1));
  assign w_hold_ok  = (r_hold_cnt >= HW'(HOLD_FRAMES));
  assign w_hold_sat = (r_hold_cnt == HW'(HOLD_FRAMES));

  // The new phase must be visible to the same FRAME_END that loads the outputs
  assign w_phase_nxt = r_phase ^ (w_frame_end & w_blk_wrap);

  // Next owner, evaluated only at frame boundaries; REQ is ignored otherwise
  always_comb begin
    w_state_nxt = r_state;
    if (w_frame_end) begin
      case (r_state)
        IDLE: begin
          if (REQ[0])      w_state_nxt = OWN0;
          else if (REQ[1]) w_state_nxt = OWN1;
          else             w_state_nxt = IDLE;
        end
        OWN0: begin
          if (REQ[0])      w_state_nxt = OWN0;
          else if (REQ[1]) w_state_nxt = OWN1;
          else             w_state_nxt = IDLE;
        end
        OWN1: begin
          if (REQ[0] && w_hold_ok) w_state_nxt = OWN0;
          else if (REQ[1])         w_state_nxt = OWN1;
          else if (REQ[0])         w_state_nxt = OWN0;
          else                     w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Content selected from the incoming owner, with blinking digits blanked in phase 1
  always_comb begin
    w_hex_nxt = '0;
    w_dp_nxt  = '0;
    w_off_nxt = OFF_ALL;
    case (w_state_nxt)
      OWN0: begin
        w_hex_nxt = HEX0;
        w_dp_nxt  = DP0;
        w_off_nxt = OFF0 | (BLINK0 & {8{w_phase_nxt}});
      end
      OWN1: begin
        w_hex_nxt = HEX1;
        w_dp_nxt  = DP1;
        w_off_nxt = OFF1 | (BLINK1 & {8{w_phase_nxt}});
      end
      default: begin
        w_hex_nxt = '0;
        w_dp_nxt  = '0;
        w_off_nxt = OFF_ALL;
      end
    endcase
  end

  // Owner state and its registered one-hot grant move together
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_gnt   <= GNT_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= gnt_of(w_state_nxt);
    end
  end

  // Blink half-period counter; the phase flips each time it wraps
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (w_frame_end) begin
      r_blk_cnt <= w_blk_wrap ? '0 : r_blk_cnt + 1'b1;
      r_phase   <= w_phase_nxt;
    end
  end

  // Frames held by the current owner, restarting whenever ownership changes
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_hold_cnt <= '0;
    end else if (w_frame_end) begin
      if (w_state_nxt != r_state) begin
        r_hold_cnt <= '0;
      end else if (!w_hold_sat) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  // Driver-facing content registers, refreshed only between frames
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_hex <= '0;
      r_dp  <= '0;
      r_off <= OFF_ALL;
    end else if (w_frame_end) begin
      r_hex <= w_hex_nxt;
      r_dp  <= w_dp_nxt;
      r_off <= w_off_nxt;
    end
  end

  assign GNT     = r_gnt;
  assign HEX_OUT = r_hex;
  assign DP_OUT  = r_dp;
  assign OFF_OUT = r_off;

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed bench for disp_scheduler with CE_DIV=4, BLINK_FRAMES=2,
// HOLD_FRAMES=2 (one frame = 32 clocks).
module tb_disp_scheduler;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [1:0]  REQ = '0;
  logic [31:0] HEX0 = '0, HEX1 = '0;
  logic [7:0]  DP0 = '0, DP1 = '0, OFF0 = '0, OFF1 = '0, BLINK0 = '0, BLINK1 = '0;
  logic [1:0]  GNT;
  logic        DISP_CE, FRAME_END;
  logic [31:0] HEX_OUT;
  logic [7:0]  DP_OUT, OFF_OUT;

  int vecCount = 0;
  int errCount = 0;

  disp_scheduler #(
    .CE_DIV(4),
    .BLINK_FRAMES(2),
    .HOLD_FRAMES(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
    .HEX0(HEX0), .HEX1(HEX1), .DP0(DP0), .DP1(DP1),
    .OFF0(OFF0), .OFF1(OFF1), .BLINK0(BLINK0), .BLINK1(BLINK1),
    .GNT(GNT), .DISP_CE(DISP_CE), .FRAME_END(FRAME_END),
    .HEX_OUT(HEX_OUT), .DP_OUT(DP_OUT), .OFF_OUT(OFF_OUT)
  );

  // Free-running 100 MHz clock
  always #5 CLK = ~CLK;

  // Hold reset for three edges, then release on a falling edge
  task automatic do_reset;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Wait for the next FRAME_END, then one more falling edge so the outputs it loaded are visible
  task automatic wait_frame_end;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (FRAME_END === 1'b1) seen = 1'b1;
    end
    vecCount++;
    if (!seen) begin
      errCount++;
      $display("[TB] FAIL frame_end_timeout: got none, expected FRAME_END within 100 cycles");
    end
    @(negedge CLK);
  endtask

  // Reset values, digit/frame cadence, and mid-frame reset restart
  task automatic test_reset;
    int firstCe, firstFe, ceCount, n;
    REQ = 2'b00;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    vecCount++; if (GNT !== 2'b00) begin errCount++; $display("[TB] FAIL rst_gnt: got %b expected 00", GNT); end
    vecCount++; if (DISP_CE !== 1'b0) begin errCount++; $display("[TB] FAIL rst_ce: got %b expected 0", DISP_CE); end
    vecCount++; if (FRAME_END !== 1'b0) begin errCount++; $display("[TB] FAIL rst_fe: got %b expected 0", FRAME_END); end
    vecCount++; if (HEX_OUT !== 32'h0) begin errCount++; $display("[TB] FAIL rst_hex: got %h expected 00000000", HEX_OUT); end
    vecCount++; if (DP_OUT !== 8'h00) begin errCount++; $display("[TB] FAIL rst_dp: got %h expected 00", DP_OUT); end
    vecCount++; if (OFF_OUT !== 8'hFF) begin errCount++; $display("[TB] FAIL rst_off: got %h expected ff", OFF_OUT); end
    RST_N = 1'b1;
    firstCe = -1; firstFe = -1; ceCount = 0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge CLK);
      if (DISP_CE === 1'b1) begin ceCount++; if (firstCe < 0) firstCe = i; end
      if (FRAME_END === 1'b1 && firstFe < 0) firstFe = i;
    end
    vecCount++; if (firstCe != 3) begin errCount++; $display("[TB] FAIL first_ce: got cycle %0d expected 3", firstCe); end
    vecCount++; if (ceCount != 8) begin errCount++; $display("[TB] FAIL ce_count: got %0d expected 8", ceCount); end
    vecCount++; if (firstFe != 31) begin errCount++; $display("[TB] FAIL first_fe: got cycle %0d expected 31", firstFe); end
    vecCount++; if (DISP_CE !== 1'b1) begin errCount++; $display("[TB] FAIL fe_with_ce: got %b expected 1", DISP_CE); end
    n = 0;
    do begin @(negedge CLK); n++; end while (FRAME_END !== 1'b1 && n < 64);
    vecCount++; if (n != 32) begin errCount++; $display("[TB] FAIL frame_period: got %0d expected 32", n); end
    repeat (10) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    vecCount++; if (DISP_CE !== 1'b0) begin errCount++; $display("[TB] FAIL midrst_ce: got %b expected 0", DISP_CE); end
    RST_N = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (DISP_CE !== 1'b1 && n < 20);
    vecCount++; if (n != 3) begin errCount++; $display("[TB] FAIL midrst_first_ce: got %0d expected 3", n); end
  endtask

  // Idle to low-priority owner, and outputs frozen mid-frame
  task automatic test_low_grant;
    REQ = 2'b10; HEX1 = 32'h1234_5678; DP1 = 8'h01; OFF1 = 8'h00; BLINK1 = 8'h00;
    HEX0 = 32'hDEAD_BEEF; DP0 = 8'h80; OFF0 = 8'h00; BLINK0 = 8'h00;
    do_reset();
    repeat (16) @(negedge CLK);
    vecCount++; if (GNT !== 2'b00) begin errCount++; $display("[TB] FAIL pre_gnt: got %b expected 00", GNT); end
    vecCount++; if (OFF_OUT !== 8'hFF) begin errCount++; $display("[TB] FAIL pre_off: got %h expected ff", OFF_OUT); end
    wait_frame_end();
    vecCount++; if (GNT !== 2'b10) begin errCount++; $display("[TB] FAIL low_gnt: got %b expected 10", GNT); end
    vecCount++; if (HEX_OUT !== 32'h1234_5678) begin errCount++; $display("[TB] FAIL low_hex: got %h expected 12345678", HEX_OUT); end
    vecCount++; if (DP_OUT !== 8'h01) begin errCount++; $display("[TB] FAIL low_dp: got %h expected 01", DP_OUT); end
    vecCount++; if (OFF_OUT !== 8'h00) begin errCount++; $display("[TB] FAIL low_off: got %h expected 00", OFF_OUT); end
    repeat (16) @(negedge CLK);
    HEX1 = 32'hAAAA_5555;
    repeat (5) @(negedge CLK);
    vecCount++; if (HEX_OUT !== 32'h1234_5678) begin errCount++; $display("[TB] FAIL midframe_hex: got %h expected 12345678", HEX_OUT); end
    HEX1 = 32'h1234_5678;
  endtask

  // Blinking low nibble digits: phase after frame end k is (k/2)%2
  task automatic test_blink;
    logic [7:0] expOff [4];
    expOff = '{8'h0F, 8'h0F, 8'h00, 8'h00};
    BLINK1 = 8'h0F;
    for (int k = 0; k < 4; k++) begin
      wait_frame_end();
      vecCount++;
      if (OFF_OUT !== expOff[k]) begin
        errCount++;
        $display("[TB] FAIL blink_off_fe%0d: got %h expected %h", k + 2, OFF_OUT, expOff[k]);
      end
    end
    BLINK1 = 8'h00;
  endtask

  // High-priority request must wait for the hold before preempting
  task automatic test_preempt;
    REQ = 2'b10;
    do_reset();
    wait_frame_end();
    vecCount++; if (GNT !== 2'b10) begin errCount++; $display("[TB] FAIL pre_fe1_gnt: got %b expected 10", GNT); end
    wait_frame_end();
    vecCount++; if (GNT !== 2'b10) begin errCount++; $display("[TB] FAIL pre_fe2_gnt: got %b expected 10", GNT); end
    REQ = 2'b11;
    wait_frame_end();
    vecCount++; if (GNT !== 2'b10) begin errCount++; $display("[TB] FAIL hold_gnt: got %b expected 10", GNT); end
    wait_frame_end();
    vecCount++; if (GNT !== 2'b01) begin errCount++; $display("[TB] FAIL preempt_gnt: got %b expected 01", GNT); end
    vecCount++; if (HEX_OUT !== 32'hDEAD_BEEF) begin errCount++; $display("[TB] FAIL preempt_hex: got %h expected deadbeef", HEX_OUT); end
    vecCount++; if (DP_OUT !== 8'h80) begin errCount++; $display("[TB] FAIL preempt_dp: got %h expected 80", DP_OUT); end
  endtask

  // Fallback to the low-priority owner, then to idle
  task automatic test_release;
    REQ = 2'b10;
    wait_frame_end();
    vecCount++; if (GNT !== 2'b10) begin errCount++; $display("[TB] FAIL fallback_gnt: got %b expected 10", GNT); end
    vecCount++; if (HEX_OUT !== 32'h1234_5678) begin errCount++; $display("[TB] FAIL fallback_hex: got %h expected 12345678", HEX_OUT); end
    REQ = 2'b00;
    wait_frame_end();
    vecCount++; if (GNT !== 2'b00) begin errCount++; $display("[TB] FAIL idle_gnt: got %b expected 00", GNT); end
    vecCount++; if (OFF_OUT !== 8'hFF) begin errCount++; $display("[TB] FAIL idle_off: got %h expected ff", OFF_OUT); end
    vecCount++; if (HEX_OUT !== 32'h0) begin errCount++; $display("[TB] FAIL idle_hex: got %h expected 00000000", HEX_OUT); end
    vecCount++; if (DP_OUT !== 8'h00) begin errCount++; $display("[TB] FAIL idle_dp: got %h expected 00", DP_OUT); end
  endtask

  // Simultaneous requests, an ignored mid-frame glitch, and immediate takeover when requester 1 drops
  task automatic test_simultaneous;
    REQ = 2'b11;
    do_reset();
    wait_frame_end();
    vecCount++; if (GNT !== 2'b01) begin errCount++; $display("[TB] FAIL both_gnt: got %b expected 01", GNT); end
    REQ = 2'b00;
    wait_frame_end();
    vecCount++; if (GNT !== 2'b00) begin errCount++; $display("[TB] FAIL drop_gnt: got %b expected 00", GNT); end
    repeat (8) @(negedge CLK);
    REQ = 2'b01;
    repeat (5) @(negedge CLK);
    REQ = 2'b00;
    wait_frame_end();
    vecCount++; if (GNT !== 2'b00) begin errCount++; $display("[TB] FAIL glitch_gnt: got %b expected 00", GNT); end
    REQ = 2'b10;
    wait_frame_end();
    vecCount++; if (GNT !== 2'b10) begin errCount++; $display("[TB] FAIL own1_gnt: got %b expected 10", GNT); end
    REQ = 2'b01;
    wait_frame_end();
    vecCount++; if (GNT !== 2'b01) begin errCount++; $display("[TB] FAIL takeover_gnt: got %b expected 01", GNT); end
    vecCount++; if (HEX_OUT !== 32'hDEAD_BEEF) begin errCount++; $display("[TB] FAIL takeover_hex: got %h expected deadbeef", HEX_OUT); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_low_grant();
    test_blink();
    test_preempt();
    test_release();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
